// File: rtl/regbank_write_arbiter_if.sv
// Write-port bus between the execution-unit requesters and the register bank arbiter.
interface regbank_write_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [AW*NREQ-1:0] req_addr;
  logic [DW*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               clr_start;
  logic               clr_busy;
  logic               clr_done;
  logic               wr_en;
  logic [AW-1:0]      wr_sel;
  logic [DW-1:0]      wr_data;
  logic [2:0]         grant_id;

  modport master (
    output req_valid, req_addr, req_data, clr_start,
    input  req_ready, clr_busy, clr_done, wr_en, wr_sel, wr_data, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, clr_start,
    output req_ready, clr_busy, clr_done, wr_en, wr_sel, wr_data, grant_id
  );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter for the register bank write port, plus a zeroing sweep.
// Optional REGBANK_ZERO_REG_EN: register 0 is hard-wired zero, so grants to address 0 drop the strobe.
module regbank_write_arbiter #(
  parameter int NREQ = 3,
  parameter int DW   = 32,
  parameter int AW   = 4
) (
  input logic                    clk,
  input logic                    rst,
  regbank_write_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_ARB, S_CLEAR, S_DONE} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [AW-1:0]   clr_cnt;
  logic            found;
  logic [PW-1:0]   gnt;
  logic [NREQ-1:0] ready;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;

  logic            wr_en_q, clr_busy_q, clr_done_q;
  logic [AW-1:0]   wr_sel_q;
  logic [DW-1:0]   wr_data_q;
  logic [2:0]      grant_id_q;

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = '0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt   = PW'(idx);
      end
    end
  end

  always_comb begin
    ready = '0;
    if (state == S_ARB && !bus.clr_start && found) ready[gnt] = 1'b1;
  end

  assign gnt_addr = bus.req_addr[AW*gnt +: AW];
  assign gnt_data = bus.req_data[DW*gnt +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_ARB;
      rr_ptr     <= '0;
      clr_cnt    <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state)
        S_ARB: begin
          clr_done_q <= 1'b0;
          if (bus.clr_start) begin
            state      <= S_CLEAR;
            clr_cnt    <= '0;
            clr_busy_q <= 1'b1;
            wr_en_q    <= 1'b0;
          end else if (found) begin
`ifdef REGBANK_ZERO_REG_EN
            wr_en_q    <= (gnt_addr != '0);
`else
            wr_en_q    <= 1'b1;
`endif
            wr_sel_q   <= gnt_addr;
            wr_data_q  <= gnt_data;
            grant_id_q <= 3'(gnt);
            rr_ptr     <= (int'(gnt) == NREQ - 1) ? '0 : gnt + PW'(1);
          end else begin
            wr_en_q <= 1'b0;
          end
        end
        S_CLEAR: begin
          wr_en_q    <= 1'b1;
          wr_sel_q   <= clr_cnt;
          wr_data_q  <= '0;
          grant_id_q <= '0;
          clr_cnt    <= clr_cnt + AW'(1);
          if (clr_cnt == '1) begin
            state      <= S_DONE;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          wr_en_q    <= 1'b0;
          clr_done_q <= 1'b0;
          state      <= S_ARB;
        end
        default: state <= S_ARB;
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.grant_id  = grant_id_q;
  assign bus.clr_busy  = clr_busy_q;
  assign bus.clr_done  = clr_done_q;
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed-vector bench for regbank_write_arbiter (NREQ=3, DW=32, AW=4).
module tb_regbank_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regbank_write_arbiter_if #(.NREQ(3), .DW(32), .AW(4)) bus();

  regbank_write_arbiter #(.NREQ(3), .DW(32), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.clr_start = 1'b0;
    do_reset();

    chk("rst_wr_en", 64'(bus.wr_en), 0);
    chk("rst_wr_sel", 64'(bus.wr_sel), 0);
    chk("rst_wr_data", 64'(bus.wr_data), 0);
    chk("rst_grant", 64'(bus.grant_id), 0);
    chk("rst_busy", 64'(bus.clr_busy), 0);
    chk("rst_done", 64'(bus.clr_done), 0);

    // single request
    bus.req_valid = 3'b001;
    bus.req_addr  = {4'd0, 4'd0, 4'd5};
    bus.req_data  = {32'd0, 32'd0, 32'hDEADBEEF};
    #1 chk("single_ready", 64'(bus.req_ready), 64'b001);
    step();
    bus.req_valid = '0;
    chk("single_wr_en", 64'(bus.wr_en), 1);
    chk("single_wr_sel", 64'(bus.wr_sel), 5);
    chk("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);
    chk("single_grant", 64'(bus.grant_id), 0);
    step();
    chk("idle_wr_en", 64'(bus.wr_en), 0);
    chk("idle_hold_sel", 64'(bus.wr_sel), 5);

    // round robin from a fresh rr_ptr: 7 grants 0,1,2,0,1,2,0 leave rr_ptr=1
    do_reset();
    bus.req_valid = 3'b111;
    bus.req_addr  = {4'd3, 4'd2, 4'd1};
    bus.req_data  = {32'hC, 32'hB, 32'hA};
    for (int c = 0; c < 7; c++) begin
      #1 chk("rr_ready", 64'(bus.req_ready), 64'(1 << (c % 3)));
      step();
      chk("rr_wr_en", 64'(bus.wr_en), 1);
      chk("rr_grant", 64'(bus.grant_id), 64'(c % 3));
      chk("rr_wr_sel", 64'(bus.wr_sel), 64'(c % 3 + 1));
      chk("rr_wr_data", 64'(bus.wr_data), 64'(c % 3 + 10));
    end

    // clear beats pending requests
    bus.clr_start = 1'b1;
    #1 chk("clr_ready_blocked", 64'(bus.req_ready), 0);
    step();
    bus.clr_start = 1'b0;
    chk("clr_first_wr_en", 64'(bus.wr_en), 0);
    chk("clr_busy_start", 64'(bus.clr_busy), 1);
    #1 chk("clr_ready_busy", 64'(bus.req_ready), 0);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("sweep_wr_en", 64'(bus.wr_en), 1);
      chk("sweep_wr_sel", 64'(bus.wr_sel), 64'(i));
      chk("sweep_wr_data", 64'(bus.wr_data), 0);
      chk("sweep_grant", 64'(bus.grant_id), 0);
      chk("sweep_busy", 64'(bus.clr_busy), 64'(i < 15));
      chk("sweep_done", 64'(bus.clr_done), 64'(i == 15));
    end
    chk("done_ready", 64'(bus.req_ready), 0);
    step();
    chk("post_done_pulse", 64'(bus.clr_done), 0);
    chk("post_wr_en", 64'(bus.wr_en), 0);
    chk("resume_rr_ptr", 64'(bus.req_ready), 64'b010);
    bus.req_valid = '0;

    // reset in the middle of a sweep
    bus.clr_start = 1'b1;
    step();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_wr_en", 64'(bus.wr_en), 0);
    chk("abort_busy", 64'(bus.clr_busy), 0);
    chk("abort_done", 64'(bus.clr_done), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.clr_done) pulses++;
      if (bus.wr_en) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 0);

    // same-address collision, later grant lands second
    bus.req_valid = 3'b011;
    bus.req_addr  = {4'd0, 4'd9, 4'd9};
    bus.req_data  = {32'd0, 32'h22, 32'h11};
    #1 chk("col_ready0", 64'(bus.req_ready), 64'b001);
    step();
    bus.req_valid = 3'b010;
    chk("col_sel0", 64'(bus.wr_sel), 9);
    chk("col_data0", 64'(bus.wr_data), 64'h11);
    #1 chk("col_ready1", 64'(bus.req_ready), 64'b010);
    step();
    bus.req_valid = '0;
    chk("col_wr_en1", 64'(bus.wr_en), 1);
    chk("col_sel1", 64'(bus.wr_sel), 9);
    chk("col_data1", 64'(bus.wr_data), 64'h22);
    chk("col_grant1", 64'(bus.grant_id), 1);
    step();
    chk("col_idle", 64'(bus.wr_en), 0);

    // write to address 0 from requester 2 (rr_ptr=2 now)
    bus.req_valid = 3'b100;
    bus.req_addr  = {4'd0, 4'd0, 4'd0};
    bus.req_data  = {32'h77, 32'd0, 32'd0};
    #1 chk("zero_ready", 64'(bus.req_ready), 64'b100);
    step();
    bus.req_valid = '0;
`ifdef REGBANK_ZERO_REG_EN
    chk("zero_wr_en", 64'(bus.wr_en), 0);
`else
    chk("zero_wr_en", 64'(bus.wr_en), 1);
    chk("zero_wr_sel", 64'(bus.wr_sel), 0);
    chk("zero_wr_data", 64'(bus.wr_data), 64'h77);
`endif
    chk("zero_grant", 64'(bus.grant_id), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regbank_write_arbiter.md
Name: regbank_write_arbiter

Overview:
- Shares the single write port of the 16-entry x 32-bit register bank among NREQ requesters, e.g. ALU writeback, load unit and immediate loader.
- Arbitration is round-robin with a valid/ready handshake.
- Also sequences a bank-clear sweep that writes zero to every register.
- Sits between the execution units and the register bank write port; its outputs drive the bank's select and data inputs through a registered write strobe.

Parameters:
- NREQ, 3, number of requesters; legal range 2..8.
- DW, 32, data width.
- AW, 4, register address width; the bank has 2**AW entries.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester write request.
- req_addr  input  AW*NREQ  packed target addresses; requester i uses bits [AW*i +: AW].
- req_data  input  DW*NREQ  packed write data; requester i uses bits [DW*i +: DW].
- req_ready  output  NREQ  per-requester accept; combinational from state and req_valid.
- clr_start  input  1  one-cycle pulse requesting a clear sweep.
- clr_busy  output  1  high while the sweep is in progress.
- clr_done  output  1  one-cycle pulse when the sweep completes.
- wr_en  output  1  registered write strobe to the bank.
- wr_sel  output  AW  registered write address.
- wr_data  output  DW  registered write data.
- grant_id  output  3  registered index of the requester that produced the current wr_en; 0 during a sweep.

Behaviour:
- Reset: state=S_ARB, rr_ptr=0, clr_cnt=0; wr_en=0, wr_sel=0, wr_data=0, grant_id=0, clr_busy=0, clr_done=0. Reset has priority over every other input.
- Handshake:
  - A transfer occurs in a cycle when req_valid[i] and req_ready[i] are both high.
  - At most one req_ready bit is high per cycle.
  - req_ready[i] must never be high unless req_valid[i] is high.
  - A requester holds valid, addr and data stable until accepted.
- S_ARB:
  - If clr_start=1: go to S_CLEAR, clr_cnt=0, no grant this cycle (all req_ready=0, wr_en=0 next cycle). Clear wins over requests.
  - Otherwise grant the first valid requester searching from rr_ptr upward, wrapping modulo NREQ.
  - On grant k: rr_ptr <= (k+1) mod NREQ.
  - Next cycle: wr_en=1, wr_sel=req_addr[k], wr_data=req_data[k], grant_id=k.
  - No valid request: wr_en=0 next cycle; wr_sel, wr_data and rr_ptr hold.
- Latency: accept in cycle t, write strobe in cycle t+1. One write per cycle sustained; back-to-back grants are allowed.
- Same-address collisions: no special handling. Each request is written in grant order, so the later grant wins in the bank.
- S_CLEAR:
  - clr_busy=1 and all req_ready=0.
  - Each cycle: next-cycle wr_en=1, wr_sel=clr_cnt, wr_data=0; then clr_cnt increments.
  - After clr_cnt=2**AW-1 is issued, go to S_DONE.
  - clr_start is ignored while in S_CLEAR.
- S_DONE:
  - Pulse clr_done=1 for one cycle; clr_busy=0; all req_ready=0.
  - Return to S_ARB next cycle. rr_ptr is unchanged across the sweep.
- Sweep duration: 2**AW cycles in S_CLEAR plus 1 cycle in S_DONE. With AW=4: clr_busy high 16 cycles, clr_done in the 17th cycle after the clr_start cycle.
- Reset during a sweep: abort immediately to S_ARB. No clr_done; wr_en=0 next cycle.
- Address bits are passed through unchanged; there is no range check because 2**AW covers the whole bank.

Optional Feature:
- Macro: REGBANK_ZERO_REG_EN.
- Defined:
  - Register 0 is hard-wired zero.
  - An arbitration grant whose req_addr is 0 is still accepted (req_ready=1, rr_ptr advances) but produces wr_en=0 next cycle.
  - The clear sweep still writes 0 to address 0.
- Undefined: address 0 behaves like every other register.

Test Plan:
- Single request: after reset, req_valid=3'b001, addr=5, data=32'hDEADBEEF -> req_ready=3'b001 the same cycle; next cycle wr_en=1, wr_sel=5, wr_data=32'hDEADBEEF, grant_id=0.
- Round-robin fairness: all three requesters valid continuously for 6 cycles -> grants 0,1,2,0,1,2; one wr_en per cycle; no requester starved.
- Clear vs request: clr_start=1 while req_valid=3'b111 -> no req_ready that cycle; wr_sel walks 0..15 with wr_data=0 over 16 cycles; clr_busy high for those 16 cycles; clr_done one pulse; arbitration resumes at the preserved rr_ptr.
- Reset mid-sweep: rst=1 when clr_cnt=7 -> next cycle state=S_ARB, wr_en=0, clr_busy=0, and clr_done never pulses.
- Collision: requesters 0 and 1 both target addr 9 with data 0x11 and 0x22, rr_ptr=0 -> writes of 0x11 then 0x22 in consecutive cycles.
- REGBANK_ZERO_REG_EN defined: request to addr 0 -> req_ready=1, wr_en stays 0. Undefined: the same stimulus gives wr_en=1, wr_sel=0.
